// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback stage: load funct3 encodings,
// the buffered-load entry layout and the default load FIFO depth.
package wb_pkg;

    localparam int unsigned WB_DEFAULT_FIFO_DEPTH = 2;

    typedef enum logic [2:0] {
        LD_LB  = 3'd0,
        LD_LH  = 3'd1,
        LD_LW  = 3'd2,
        LD_LBU = 3'd4,
        LD_LHU = 3'd5
    } ld_funct3_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] value;
    } wb_entry_t;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Combinational load data extraction: picks the byte/halfword addressed by
// addr_lo out of the aligned memory word and sign- or zero-extends it.
module load_extend
    import wb_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            LD_LB:   value = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  value = {24'h0, byte_sel};
            LD_LH:   value = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  value = {16'h0, half_sel};
            LD_LW:   value = word;
            default: value = '0;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Register-file writeback: merges the ALU channel with a FIFO of returned loads.
// Optional `WB_SCOREBOARD_EN adds a 'pending' destination-register bitmap.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int unsigned LOAD_FIFO_DEPTH = WB_DEFAULT_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_value,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_word,
    output logic        rf_write_enable,
    output logic [4:0]  rf_address_write,
    output logic [31:0] rf_value_write
`ifdef WB_SCOREBOARD_EN
    ,
    output logic [31:0] pending
`endif
);

    localparam int unsigned PTR_W = (LOAD_FIFO_DEPTH > 1) ? $clog2(LOAD_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LOAD_FIFO_DEPTH);

    wb_entry_t         fifo_q [LOAD_FIFO_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_addr_q, rf_addr_d;
    logic [31:0]       rf_val_q, rf_val_d;

    logic              full, empty, ready;
    logic              ld_fire, alu_fire, deq;
    logic [31:0]       ld_ext_value;
    wb_entry_t         win;
    logic              win_valid;

    load_extend u_load_extend (
        .funct3  (ld_funct3),
        .addr_lo (ld_addr_lo),
        .word    (ld_word),
        .value   (ld_ext_value)
    );

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign ready     = !reset && !full;
    assign alu_ready = ready;
    assign ld_ready  = ready;
    assign ld_fire   = ld_valid && ready;
    assign alu_fire  = alu_valid && ready;

    // A full FIFO forces the head load out so the ALU stall lasts one cycle.
    always_comb begin
        deq       = 1'b0;
        win_valid = 1'b0;
        win       = '0;
        if (full) begin
            deq       = 1'b1;
            win_valid = 1'b1;
            win       = fifo_q[head_q];
        end else if (alu_fire) begin
            win_valid = 1'b1;
            win.rd    = alu_rd;
            win.value = alu_value;
        end else if (!empty) begin
            deq       = 1'b1;
            win_valid = 1'b1;
            win       = fifo_q[head_q];
        end
    end

    always_comb begin
        head_d    = deq ? head_q + PTR_W'(1) : head_q;
        tail_d    = ld_fire ? tail_q + PTR_W'(1) : tail_q;
        count_d   = count_q + CNT_W'(ld_fire) - CNT_W'(deq);
        rf_we_d   = win_valid && (win.rd != 5'd0);
        rf_addr_d = rf_we_d ? win.rd : 5'd0;
        rf_val_d  = rf_we_d ? win.value : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_val_q  <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_val_q  <= rf_val_d;
            if (ld_fire) begin
                fifo_q[tail_q] <= '{rd: ld_rd, value: ld_ext_value};
            end
        end
    end

    assign rf_write_enable  = rf_we_q;
    assign rf_address_write = rf_addr_q;
    assign rf_value_write   = rf_val_q;

`ifdef WB_SCOREBOARD_EN
    logic [31:0] pend;

    always_comb begin
        pend = '0;
        for (int unsigned i = 0; i < LOAD_FIFO_DEPTH; i++) begin
            if (CNT_W'(i) < count_q) begin
                pend[fifo_q[PTR_W'(head_q + PTR_W'(i))].rd] = 1'b1;
            end
        end
        if (rf_we_q) begin
            pend[rf_addr_q] = 1'b1;
        end
        pend[0] = 1'b0;
    end

    assign pending = pend;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed table-driven bench for writeback_stage plus hand-written ordering
// and (with WB_SCOREBOARD_EN) pending-bitmap sequences.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_value;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic [31:0] ld_word;
    logic        rf_write_enable;
    logic [4:0]  rf_address_write;
    logic [31:0] rf_value_write;
`ifdef WB_SCOREBOARD_EN
    logic [31:0] pending;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    writeback_stage #(.LOAD_FIFO_DEPTH(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .alu_valid        (alu_valid),
        .alu_ready        (alu_ready),
        .alu_rd           (alu_rd),
        .alu_value        (alu_value),
        .ld_valid         (ld_valid),
        .ld_ready         (ld_ready),
        .ld_rd            (ld_rd),
        .ld_funct3        (ld_funct3),
        .ld_addr_lo       (ld_addr_lo),
        .ld_word          (ld_word),
        .rf_write_enable  (rf_write_enable),
        .rf_address_write (rf_address_write),
        .rf_value_write   (rf_value_write)
`ifdef WB_SCOREBOARD_EN
        ,
        .pending          (pending)
`endif
    );

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] aval;
        logic        lv;
        logic [4:0]  lrd;
        logic [2:0]  f3;
        logic [1:0]  alo;
        logic [31:0] word;
        logic        ewe;
        logic [4:0]  eaddr;
        logic [31:0] evalue;
        logic        erdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int unsigned rst, input int unsigned av,
                                input int unsigned ard, input logic [31:0] aval,
                                input int unsigned lv, input int unsigned lrd,
                                input int unsigned f3, input int unsigned alo,
                                input logic [31:0] word, input int unsigned ewe,
                                input int unsigned eaddr, input logic [31:0] evalue,
                                input int unsigned erdy);
        vec_t v;
        v.rst    = 1'(rst);
        v.av     = 1'(av);
        v.ard    = 5'(ard);
        v.aval   = aval;
        v.lv     = 1'(lv);
        v.lrd    = 5'(lrd);
        v.f3     = 3'(f3);
        v.alo    = 2'(alo);
        v.word   = word;
        v.ewe    = 1'(ewe);
        v.eaddr  = 5'(eaddr);
        v.evalue = evalue;
        v.erdy   = 1'(erdy);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        reset     = 1'b0;
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_value = '0;
        ld_valid  = 1'b0;
        ld_rd     = '0;
        ld_funct3 = '0;
        ld_addr_lo = '0;
        ld_word   = '0;
    endtask

    // Waits (bounded) for the next write and checks its address/value.
    task automatic wait_write(input string name, input logic [4:0] eaddr, input logic [31:0] evalue);
        bit seen = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(posedge clk);
            #1;
            if (rf_write_enable) seen = 1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no write expected addr %0d", name, eaddr);
        end else begin
            chk({name, "_addr"}, 32'(rf_address_write), 32'(eaddr));
            chk({name, "_val"}, rf_value_write, evalue);
        end
    endtask

    initial begin
        idle_inputs();

        //             rst av ard aval           lv lrd f3 alo word            ewe eaddr evalue         erdy
        vecs.push_back(mk(1, 0, 0,  32'h0,        0, 0,  0, 0, 32'h0,          0, 0,  32'h0,          0));
        vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 0, 32'h0,          0, 0,  32'h0,          1));
        vecs.push_back(mk(0, 1, 5,  32'h1234,     0, 0,  0, 0, 32'h0,          1, 5,  32'h1234,       1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 0, 32'h0,          0, 0,  32'h0,          1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        1, 3,  0, 2, 32'h00800000,   0, 0,  32'h0,          1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 0, 32'h0,          1, 3,  32'hFFFFFF80,   1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        1, 4,  5, 2, 32'h80010000,   0, 0,  32'h0,          1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 0, 32'h0,          1, 4,  32'h00008001,   1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        1, 9,  2, 0, 32'hCAFEF00D,   0, 0,  32'h0,          1));
        vecs.push_back(mk(0, 1, 1,  32'h11,       0, 0,  0, 0, 32'h0,          1, 1,  32'h11,         1));
        vecs.push_back(mk(0, 1, 2,  32'h22,       0, 0,  0, 0, 32'h0,          1, 2,  32'h22,         1));
        vecs.push_back(mk(0, 1, 3,  32'h33,       0, 0,  0, 0, 32'h0,          1, 3,  32'h33,         1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 0, 32'h0,          1, 9,  32'hCAFEF00D,   1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        1, 10, 2, 0, 32'hA,          0, 0,  32'h0,          1));
        vecs.push_back(mk(0, 1, 12, 32'hC,        1, 11, 2, 0, 32'hB,          1, 12, 32'hC,          0));
        vecs.push_back(mk(0, 1, 13, 32'hD,        1, 14, 2, 0, 32'hE,          1, 10, 32'hA,          1));
        vecs.push_back(mk(0, 1, 13, 32'hD,        0, 0,  0, 0, 32'h0,          1, 13, 32'hD,          1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 0, 32'h0,          1, 11, 32'hB,          1));
        vecs.push_back(mk(0, 1, 0,  32'hDEAD,     0, 0,  0, 0, 32'h0,          0, 0,  32'h0,          1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        1, 0,  2, 0, 32'h55,         0, 0,  32'h0,          1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 0, 32'h0,          0, 0,  32'h0,          1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        1, 6,  0, 1, 32'h00007F00,   0, 0,  32'h0,          1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 0, 32'h0,          1, 6,  32'h7F,         1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        1, 7,  3, 0, 32'hFFFFFFFF,   0, 0,  32'h0,          1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 0, 32'h0,          1, 7,  32'h0,          1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        1, 8,  4, 3, 32'h80000000,   0, 0,  32'h0,          1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 0, 32'h0,          1, 8,  32'h80,         1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        1, 9,  1, 0, 32'h00008000,   0, 0,  32'h0,          1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 0, 32'h0,          1, 9,  32'hFFFF8000,   1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        1, 20, 2, 0, 32'h1,          0, 0,  32'h0,          1));
        vecs.push_back(mk(0, 1, 22, 32'h3,        1, 21, 2, 0, 32'h2,          1, 22, 32'h3,          0));
        vecs.push_back(mk(1, 1, 23, 32'h4,        1, 24, 2, 0, 32'h5,          0, 0,  32'h0,          0));
        vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 0, 32'h0,          0, 0,  32'h0,          1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 0, 32'h0,          0, 0,  32'h0,          1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        1, 15, 2, 0, 32'h15,         0, 0,  32'h0,          1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        1, 16, 2, 0, 32'h16,         1, 15, 32'h15,         1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 0, 32'h0,          1, 16, 32'h16,         1));

        foreach (vecs[i]) begin
            @(negedge clk);
            reset      = vecs[i].rst;
            alu_valid  = vecs[i].av;
            alu_rd     = vecs[i].ard;
            alu_value  = vecs[i].aval;
            ld_valid   = vecs[i].lv;
            ld_rd      = vecs[i].lrd;
            ld_funct3  = vecs[i].f3;
            ld_addr_lo = vecs[i].alo;
            ld_word    = vecs[i].word;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_we", i), 32'(rf_write_enable), 32'(vecs[i].ewe));
            chk($sformatf("v%0d_addr", i), 32'(rf_address_write), 32'(vecs[i].eaddr));
            chk($sformatf("v%0d_val", i), rf_value_write, vecs[i].evalue);
            chk($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(vecs[i].erdy));
            chk($sformatf("v%0d_ld_ready", i), 32'(ld_ready), 32'(vecs[i].erdy));
        end

        // Fill the FIFO behind a streaming ALU, then drain in load order.
        @(negedge clk);
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_value = 32'h100;
        ld_valid = 1'b1; ld_rd = 5'd24; ld_funct3 = 3'd2; ld_word = 32'h24;
        @(negedge clk);
        ld_rd = 5'd25; ld_word = 32'h25;
        @(negedge clk);
        chk("order_full_ready", 32'(ld_ready), 32'd0);
        alu_valid = 1'b0;
        ld_valid = 1'b0;
        wait_write("order_first", 5'd24, 32'h24);
        wait_write("order_second", 5'd25, 32'h25);

`ifdef WB_SCOREBOARD_EN
        @(negedge clk);
        idle_inputs();
        chk("sb_idle", pending, 32'h0);
        ld_valid = 1'b1; ld_rd = 5'd7; ld_funct3 = 3'd2; ld_word = 32'h77;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_value = 32'h1;
        @(posedge clk);
        #1;
        chk("sb_enq_bit7", 32'(pending[7]), 32'd1);
        @(negedge clk);
        ld_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("sb_held_bit7", 32'(pending[7]), 32'd1);
        @(negedge clk);
        alu_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("sb_write_we", 32'(rf_write_enable), 32'd1);
        chk("sb_write_addr", 32'(rf_address_write), 32'd7);
        chk("sb_write_bit7", 32'(pending[7]), 32'd1);
        @(posedge clk);
        #1;
        chk("sb_after", pending, 32'h0);
`endif

        @(negedge clk);
        idle_inputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
